// File: rtl/psum_collector_pkg.sv
// Shared definitions for the PE partial-sum collector.
//   ps_state_e    : collector FSM states
//   ACCWD_DEFAULT : default accumulator / output width
//   sat_limit()   : largest or smallest signed value representable in a width
package psum_collector_pkg;

  localparam int ACCWD_DEFAULT = 20;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } ps_state_e;

  // Signed range limit for a two's-complement value of the given width.
  // Works for widths up to 31 bits.
  function automatic int sat_limit(input int width, input bit want_max);
    int mag;
    mag = 1 << (width - 1);
    return want_max ? (mag - 1) : -mag;
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// One row of the partial-sum collector: a signed ACCWD-bit accumulator
// with saturating add and a sticky saturation flag.
//   i_clk, i_rst : clock, synchronous active-low reset
//   clr          : zero the accumulator and flag (takes priority over en)
//   en           : add din into the accumulator this cycle
//   din          : signed DWD-bit row sum
//   acc          : signed accumulator value
//   sat          : set once any add in this pass was clamped
module psum_sat_add
  import psum_collector_pkg::*;
#(
  parameter int DWD   = 8,
  parameter int ACCWD = ACCWD_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DWD-1:0]   din,
  output logic signed [ACCWD-1:0] acc,
  output logic                    sat
);

  localparam int MAX_I = sat_limit(ACCWD, 1'b1);
  localparam int MIN_I = sat_limit(ACCWD, 1'b0);
  localparam logic signed [ACCWD:0] ACC_MAX = (ACCWD + 1)'(MAX_I);
  localparam logic signed [ACCWD:0] ACC_MIN = (ACCWD + 1)'(MIN_I);

  logic signed [ACCWD:0]   sum_wide;
  logic signed [ACCWD-1:0] sum_clamped;
  logic                    clamp;

  // One guard bit is enough: both operands fit in ACCWD signed bits
  // (ACCWD >= DWD), so their sum cannot overflow ACCWD+1 bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    clamp       = 1'b0;
    sum_wide    = $signed({{(ACCWD + 1 - DWD){din[DWD-1]}}, din})
                + $signed({acc[ACCWD-1], acc});
    sum_clamped = sum_wide[ACCWD-1:0];
    if (sum_wide > ACC_MAX) begin
      sum_clamped = ACC_MAX[ACCWD-1:0];
      clamp       = 1'b1;
    end else if (sum_wide < ACC_MIN) begin
      sum_clamped = ACC_MIN[ACCWD-1:0];
      clamp       = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (en) begin
      acc <= sum_clamped;
      sat <= sat | clamp;
    end
  end

endmodule

// File: rtl/psum_collector.sv
// PE partial-sum collector. Accepts i_len vectors of PEROW signed row sums
// per pass, accumulates them per row with saturation, then offers the
// result downstream on a valid/ready handshake.
//   i_clk, i_rst       : clock, synchronous active-low reset
//   i_start, i_len     : begin a pass of max(i_len,1) vectors
//   i_sum_valid/o_sum_ready, i_sum   : input vector handshake
//   o_psum_valid/i_psum_ready, o_psum, o_sat : result handshake
//   o_busy             : FSM is not in IDLE
// ACCWD must be at least DWD.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int DWD   = 8,
  parameter int PEROW = 4,
  parameter int ACCWD = ACCWD_DEFAULT,
  parameter int CNTWD = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  input  logic [CNTWD-1:0]                  i_len,
  input  logic                              i_sum_valid,
  output logic                              o_sum_ready,
  input  logic [PEROW-1:0][DWD-1:0]         i_sum,
  output logic                              o_psum_valid,
  input  logic                              i_psum_ready,
  output logic [PEROW-1:0][ACCWD-1:0]       o_psum,
  output logic [PEROW-1:0]                  o_sat,
  output logic                              o_busy
);

  ps_state_e        state;
  logic [CNTWD-1:0] len_q;
  logic [CNTWD-1:0] cnt;
  logic [CNTWD-1:0] len_eff;
  logic             sum_hs;
  logic             start_ok;
  logic             last_sum;

  // A start is honoured from IDLE, or in DRAIN together with the result
  // handshake so consecutive passes run without an idle bubble.
  always_comb begin
    sum_hs   = i_sum_valid & o_sum_ready;
    start_ok = i_start & ((state == IDLE) | ((state == DRAIN) & i_psum_ready));
    len_eff  = (i_len == '0) ? CNTWD'(1) : i_len;
    last_sum = (cnt == (len_q - CNTWD'(1)));
  end

  for (genvar r = 0; r < PEROW; r++) begin : g_row
    psum_sat_add #(
      .DWD  (DWD),
      .ACCWD(ACCWD)
    ) u_add (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .clr  (start_ok),
      .en   (sum_hs),
      .din  (i_sum[r]),
      .acc  (o_psum[r]),
      .sat  (o_sat[r])
    );
  end

  // Handshake outputs are registered alongside the state so they depend
  // only on the state, never combinationally on i_sum_valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state        <= IDLE;
      len_q        <= '0;
      cnt          <= '0;
      o_sum_ready  <= 1'b0;
      o_psum_valid <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            state       <= ACCUM;
            len_q       <= len_eff;
            cnt         <= '0;
            o_sum_ready <= 1'b1;
            o_busy      <= 1'b1;
          end
        end
        ACCUM: begin
          if (sum_hs) begin
            cnt <= cnt + CNTWD'(1);
            if (last_sum) begin
              state        <= DRAIN;
              o_sum_ready  <= 1'b0;
              o_psum_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (i_psum_ready) begin
            o_psum_valid <= 1'b0;
            if (start_ok) begin
              state       <= ACCUM;
              len_q       <= len_eff;
              cnt         <= '0;
              o_sum_ready <= 1'b1;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: begin
          state        <= IDLE;
          o_sum_ready  <= 1'b0;
          o_psum_valid <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Downstream consumer of the per-row arithmetic-unit outputs in the PE.
- Accepts one PEROW-wide vector of signed DWD-bit sums per handshake and accumulates i_len vectors per pass into per-row saturating accumulators.
- Presents the accumulated partial sums to the PE output path through a valid/ready handshake.
- Sits between the arithmetic-unit row array and the PE psum writeback.

Parameters:
- DWD, from PECfg: width of each incoming row sum (signed).
- PEROW, from PECfg: number of rows/lanes.
- ACCWD, 20: accumulator and output width, signed. Constraint: ACCWD >= DWD.
- CNTWD, 8: width of the pass-length field and the internal counter.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset. Synchronous, active-low.
- i_start  input  1  begin a pass; sampled only when the FSM can accept it.
- i_len  input  CNTWD  number of sum vectors in the pass, latched on start; 0 is treated as 1.
- i_sum_valid  input  1  i_sum vector valid.
- o_sum_ready  output  1  collector accepts i_sum.
- i_sum  input  DWD x PEROW  signed row sums.
- o_psum_valid  output  1  accumulated result valid.
- i_psum_ready  input  1  downstream accepts o_psum.
- o_psum  output  ACCWD x PEROW  signed accumulated sums.
- o_sat  output  PEROW  per-row flag: saturation occurred this pass.
- o_busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (i_rst==0 at a clock edge):
  - FSM goes to IDLE.
  - All accumulators, counter, o_psum and o_sat clear to 0.
  - o_sum_ready, o_psum_valid and o_busy are 0.
  - Reset mid-pass discards the pass with no output.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - o_sum_ready=0.
  - On i_start: latch len=max(i_len,1), clear accumulators, o_sat and counter, and go to ACCUM next cycle.
- ACCUM:
  - o_sum_ready=1.
  - A handshake (i_sum_valid & o_sum_ready) sign-extends each i_sum[r] to ACCWD+1 bits and adds it to acc[r].
  - The result saturates to [-2^(ACCWD-1), 2^(ACCWD-1)-1]; on clamp, o_sat[r] sets sticky.
  - The counter increments on each handshake.
  - The handshake where count==len-1 moves the FSM to DRAIN.
  - Cycles without valid hold all state.
  - i_start is ignored.
- DRAIN:
  - o_psum_valid=1; o_psum=acc and o_sat are held stable until accepted.
  - o_sum_ready=0.
  - On i_psum_ready: if i_start is also high, re-latch i_len, clear accumulators and go to ACCUM (back-to-back pass, no idle bubble). Otherwise go to IDLE.
  - o_psum and o_sat keep their last values in IDLE until the next start clears them.
- Latency:
  - The last sum is accepted at edge t; o_psum_valid=1 in the cycle after edge t.
  - Minimum pass length len=1 takes 3 cycles from start to the drain handshake: start, accept, drain.
- Valid/ready rules:
  - o_psum_valid, once asserted, stays high until a handshake.
  - o_sum_ready depends only on state, with no combinational path from i_sum_valid.
  - i_psum_ready may toggle arbitrarily.
- Counter: counts 0..len-1, cannot wrap (len<=2^CNTWD-1).

Decomposition:
- PECtlCfg package holds:
  - typedef enum PsState {IDLE, ACCUM, DRAIN}
  - the ACCWD default constant
  - a saturation-limit function returning max/min for a given width
- Sub-module psum_sat_add: one per row via generate. Contains the ACCWD register, the sign-extend + saturating add, the sticky sat flag, and clear/enable inputs.
- The top level holds the FSM, the counter and the handshakes.

Test Plan (build DWD=8, PEROW=4; ACCWD=10 for the saturation case):
- Basic pass:
  - Stimulus: start len=3; sums {1,2,3,4},{10,-2,0,5},{-1,0,7,1} sent back-to-back, psum_ready=1.
  - Required: o_psum={10,0,10,10}, o_sat=0, valid exactly 1 cycle after the 3rd accept.
- Gaps and backpressure:
  - Stimulus: same data with valid gaps; psum_ready=0 for 4 cycles after valid.
  - Required: o_psum stays {10,0,10,10} and stable, no extra accepts, IDLE after ready.
- Saturation (ACCWD=10):
  - Stimulus: len=5, row0 input 127 x5, row1 input -128 x5.
  - Required: o_psum[0]=511, o_psum[1]=-512, o_sat=4'b0011.
- len=0 and back-to-back:
  - Stimulus: start i_len=0 with sum {5,5,5,5}; assert start together with the drain handshake, i_len=2, then {1,1,1,1} x2.
  - Required: first result {5,5,5,5}, second {2,2,2,2}, with no IDLE cycle between passes.
- Reset mid-pass:
  - Stimulus: i_rst=0 after 2 of 4 accepts, then a new pass len=1 with {3,3,3,3}.
  - Required: all outputs 0 in the reset cycle, next result {3,3,3,3} with no residue.
- Start ignored during ACCUM:
  - Stimulus: pulse i_start mid-pass with i_len=7.
  - Required: the pass still ends after the original len.
